// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module : board_pkg
// Brief  : Shared cell codes, neighbour offset table, scan FSM states and the
//          cell-index helper for the board cell engine.
// Rev    : 1.0
// ============================================================================
package board_pkg;

  localparam int CELL_EMPTY = 0;
  localparam int NBR_COUNT  = 8;

  // Neighbour walk order: row above, same row, row below.
  localparam logic signed [1:0] NBR_DX [NBR_COUNT] =
    '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
  localparam logic signed [1:0] NBR_DY [NBR_COUNT] =
    '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  function automatic int cell_index(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_coord_wrap.sv
`default_nettype none
// ============================================================================
// Module : board_coord_wrap
// Brief  : Centre + signed offset -> neighbour coordinate and on-board flag.
//          BOARD_TORUS_EN selects wrap-around edges instead of skipping.
// Rev    : 1.0
// ============================================================================
module board_coord_wrap #(
  parameter int BOARD_W    = 8,
  parameter int BOARD_H    = 8,
  parameter int COORD_BITS = 4
) (
  input  logic [COORD_BITS-1:0] cx,
  input  logic [COORD_BITS-1:0] cy,
  input  logic signed [1:0]     dx,
  input  logic signed [1:0]     dy,
  output logic [COORD_BITS-1:0] nx,
  output logic [COORD_BITS-1:0] ny,
  output logic                  on_board
);

  int w_sx;
  int w_sy;

  always_comb begin
    w_sx = int'(cx) + int'(dx);
    w_sy = int'(cy) + int'(dy);
`ifdef BOARD_TORUS_EN
    if (w_sx < 0)        w_sx = w_sx + BOARD_W;
    if (w_sx >= BOARD_W) w_sx = w_sx - BOARD_W;
    if (w_sy < 0)        w_sy = w_sy + BOARD_H;
    if (w_sy >= BOARD_H) w_sy = w_sy - BOARD_H;
    on_board = 1'b1;
`else
    on_board = (w_sx >= 0) && (w_sx < BOARD_W) && (w_sy >= 0) && (w_sy < BOARD_H);
`endif
    nx = w_sx[COORD_BITS-1:0];
    ny = w_sy[COORD_BITS-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/board_cell_engine.sv
`default_nettype none
// ============================================================================
// Module : board_cell_engine
// Brief  : Registered game board with cell read/write and a sequential
//          8-neighbour match counter. Build option: BOARD_TORUS_EN.
// Rev    : 1.0
// ============================================================================
module board_cell_engine
  import board_pkg::*;
#(
  parameter int BOARD_W    = 8,
  parameter int BOARD_H    = 8,
  parameter int CELL_BITS  = 3,
  parameter int COORD_BITS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_valid,
  input  logic [COORD_BITS-1:0]             rd_x,
  input  logic [COORD_BITS-1:0]             rd_y,
  output logic [CELL_BITS-1:0]              rd_status,
  output logic                              rd_ack,
  output logic                              rd_err,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [COORD_BITS-1:0]             wr_x,
  input  logic [COORD_BITS-1:0]             wr_y,
  input  logic [CELL_BITS-1:0]              wr_status,
  input  logic                              scan_start,
  input  logic [COORD_BITS-1:0]             scan_x,
  input  logic [COORD_BITS-1:0]             scan_y,
  input  logic [CELL_BITS-1:0]              scan_match,
  output logic                              scan_busy,
  output logic                              scan_done,
  output logic                              scan_err,
  output logic [3:0]                        scan_count,
  output logic [BOARD_W*BOARD_H*CELL_BITS-1:0] board_state
);

  localparam int c_board_bits = BOARD_W * BOARD_H * CELL_BITS;

  scan_state_t               r_state;
  logic [2:0]                r_k;
  logic [COORD_BITS-1:0]     r_cx;
  logic [COORD_BITS-1:0]     r_cy;
  logic [CELL_BITS-1:0]      r_match;
  logic [3:0]                r_count;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_err;
  logic                      r_wr_ready;
  logic [CELL_BITS-1:0]      r_rd_status;
  logic                      r_rd_ack;
  logic                      r_rd_err;
  logic [c_board_bits-1:0]   r_board;

  logic                  w_rd_on;
  logic                  w_wr_on;
  logic                  w_sc_on;
  int                    w_rd_idx;
  int                    w_wr_idx;
  int                    w_nbr_idx;
  logic [COORD_BITS-1:0] w_nx;
  logic [COORD_BITS-1:0] w_ny;
  logic                  w_nbr_on;
  logic [CELL_BITS-1:0]  w_rd_code;
  logic [CELL_BITS-1:0]  w_nbr_code;
  logic                  w_hit;

  assign w_rd_on = (int'(rd_x) < BOARD_W) && (int'(rd_y) < BOARD_H);
  assign w_wr_on = (int'(wr_x) < BOARD_W) && (int'(wr_y) < BOARD_H);
  assign w_sc_on = (int'(scan_x) < BOARD_W) && (int'(scan_y) < BOARD_H);

  board_coord_wrap #(
    .BOARD_W    (BOARD_W),
    .BOARD_H    (BOARD_H),
    .COORD_BITS (COORD_BITS)
  ) u_coord_wrap (
    .cx       (r_cx),
    .cy       (r_cy),
    .dx       (NBR_DX[r_k]),
    .dy       (NBR_DY[r_k]),
    .nx       (w_nx),
    .ny       (w_ny),
    .on_board (w_nbr_on)
  );

  // Indices are forced to 0 when off-board so selects never leave the vector.
  always_comb begin
    w_rd_idx  = 0;
    w_wr_idx  = 0;
    w_nbr_idx = 0;
    if (w_rd_on)  w_rd_idx  = cell_index(int'(rd_x), int'(rd_y), BOARD_W);
    if (w_wr_on)  w_wr_idx  = cell_index(int'(wr_x), int'(wr_y), BOARD_W);
    if (w_nbr_on) w_nbr_idx = cell_index(int'(w_nx), int'(w_ny), BOARD_W);
  end

  assign w_rd_code  = r_board[w_rd_idx*CELL_BITS +: CELL_BITS];
  assign w_nbr_code = r_board[w_nbr_idx*CELL_BITS +: CELL_BITS];
  assign w_hit      = w_nbr_on && (w_nbr_code == r_match);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_match     <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_status <= '0;
      r_rd_ack    <= 1'b0;
      r_rd_err    <= 1'b0;
      r_board     <= '0;
    end else begin
      r_rd_ack <= rd_valid;
      r_rd_err <= rd_valid && !w_rd_on;
      if (rd_valid) r_rd_status <= w_rd_on ? w_rd_code : CELL_BITS'(CELL_EMPTY);

      if (wr_valid && r_wr_ready && w_wr_on)
        r_board[w_wr_idx*CELL_BITS +: CELL_BITS] <= wr_status;

      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wr_ready <= 1'b1;
          if (scan_start) begin
            r_cx       <= scan_x;
            r_cy       <= scan_y;
            r_match    <= scan_match;
            r_count    <= '0;
            r_k        <= '0;
            r_wr_ready <= 1'b0;
            if (w_sc_on) begin
              r_state <= SCAN;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (w_hit && (r_count < 4'd8)) r_count <= r_count + 4'd1;
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_wr_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_status   = r_rd_status;
  assign rd_ack      = r_rd_ack;
  assign rd_err      = r_rd_err;
  assign wr_ready    = r_wr_ready;
  assign scan_busy   = r_busy;
  assign scan_done   = r_done;
  assign scan_err    = r_err;
  assign scan_count  = r_count;
  assign board_state = r_board;

endmodule
`default_nettype wire
